// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryption core (128/192/256-bit keys): key schedule expanded one word per cycle,
// then one round per cycle. Define AES_KEY_CACHE_EN to reuse the schedule when the key repeats.
module aes_encrypt_iter #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);

    localparam int unsigned Nk       = KEY_BITS / 32;
    localparam int unsigned Nr       = Nk + 6;
    localparam int unsigned NumWords = 4 * (Nr + 1);

    localparam logic [5:0] NkW   = 6'(Nk);
    localparam logic [5:0] LastW = 6'(NumWords - 1);
    localparam logic [2:0] NkM1  = 3'(Nk - 1);
    localparam logic [3:0] NrL   = 4'(Nr);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : gen_key_bits_check
        $error("aes_encrypt_iter: KEY_BITS must be 128, 192 or 256");
    end

    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SboxTable[8*(255-int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    typedef enum logic [1:0] {StIdle, StExpand, StRound, StDone} state_e;

    state_e         state_q;
    logic           in_ready_q, out_valid_q, busy_q;
    logic [127:0]   out_data_q;
    logic [127:0]   data_q;
    logic [31:0]    w_q [NumWords];
    logic [5:0]     i_q;
    logic [2:0]     k_q;     // i_q mod Nk, tracked incrementally
    logic [7:0]     rcon_q;
    logic [3:0]     r_q;
    logic           cache_hit;

`ifdef AES_KEY_CACHE_EN
    logic [KEY_BITS-1:0] key_q;
    logic                cache_valid_q;
    assign cache_hit = cache_valid_q && (in_key == key_q);
`else
    assign cache_hit = 1'b0;
`endif

    // Key schedule: a single SubWord shared by the rotate and the 256-bit mid-block step.
    logic [31:0] w_prev, w_back, sw_in, sw_out, w_new;
    always_comb begin
        w_prev = w_q[i_q - 6'd1];
        w_back = w_q[i_q - NkW];
        sw_in  = (k_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        sw_out = sub_word(sw_in);
        if (k_q == 3'd0) begin
            w_new = w_back ^ sw_out ^ {rcon_q, 24'h0};
        end else if (Nk == 8 && k_q == 3'd4) begin
            w_new = w_back ^ sw_out;
        end else begin
            w_new = w_back ^ w_prev;
        end
    end

    logic [5:0]   rk_idx;
    logic [127:0] rk, sb, sr, mc, round_next;
    always_comb begin
        rk_idx = {r_q, 2'b00};
        rk     = {w_q[rk_idx], w_q[rk_idx + 6'd1], w_q[rk_idx + 6'd2], w_q[rk_idx + 6'd3]};
        sb     = '0;
        sr     = '0;
        mc     = '0;
        for (int n = 0; n < 16; n++) begin
            sb[127-8*n -: 8] = sbox(data_q[127-8*n -: 8]);
        end
        // Byte (row r, column c) takes row r of column (c + r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
        end
        if (r_q == 4'd0) begin
            round_next = data_q ^ rk;
        end else if (r_q == NrL) begin
            round_next = sr ^ rk;
        end else begin
            round_next = mc ^ rk;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
            data_q      <= '0;
            rcon_q      <= 8'h01;
            i_q         <= '0;
            k_q         <= '0;
            r_q         <= '0;
`ifdef AES_KEY_CACHE_EN
            cache_valid_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        r_q        <= '0;
                        if (cache_hit) begin
                            state_q <= StRound;
                        end else begin
                            for (int j = 0; j < Nk; j++) begin
                                w_q[j] <= in_key[KEY_BITS-1-32*j -: 32];
                            end
                            i_q     <= NkW;
                            k_q     <= '0;
                            rcon_q  <= 8'h01;
                            state_q <= StExpand;
`ifdef AES_KEY_CACHE_EN
                            key_q   <= in_key;
`endif
                        end
                    end
                end
                StExpand: begin
                    w_q[i_q] <= w_new;
                    i_q      <= i_q + 6'd1;
                    k_q      <= (k_q == NkM1) ? 3'd0 : k_q + 3'd1;
                    if (k_q == 3'd0) begin
                        rcon_q <= xtime(rcon_q);
                    end
                    if (i_q == LastW) begin
                        state_q <= StRound;
                        r_q     <= '0;
`ifdef AES_KEY_CACHE_EN
                        cache_valid_q <= 1'b1;
`endif
                    end
                end
                StRound: begin
                    data_q <= round_next;
                    r_q    <= r_q + 4'd1;
                    if (r_q == NrL) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        out_data_q  <= round_next;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Scoreboard bench for aes_encrypt_iter: a driver pushes expected ciphertext/latency, a monitor
// checks each presented result against a byte-level AES model built from GF(2^8) arithmetic.
module tb_aes_encrypt_iter;
    parameter int unsigned KEY_BITS = 128;
    localparam int unsigned NK       = KEY_BITS / 32;
    localparam int unsigned NR       = NK + 6;
    localparam int unsigned FULL_LAT = 4 * NR + 4 - NK + NR + 1;
    localparam int unsigned HIT_LAT  = NR + 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b1;
    logic [127:0]        in_data = '0;
    logic [KEY_BITS-1:0] in_key = '0;
    logic                in_ready, out_valid, busy;
    logic [127:0]        out_data;

    aes_encrypt_iter #(.KEY_BITS(KEY_BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] ct;
        int unsigned  acc;
        int unsigned  lat;
    } exp_t;
    exp_t exp_q[$];

    logic                cache_v = 1'b0;
    logic [KEY_BITS-1:0] cache_key = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                        ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] pt,
                                               input logic [KEY_BITS-1:0] key);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < NK; i++) w[i] = key[KEY_BITS-1-32*i -: 32];
        for (int i = NK; i < 4 * (NR + 1); i++) begin
            tmp = w[i-1];
            if (i % NK == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (NK > 6 && i % NK == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-NK] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8];
        for (int r = 0; r <= NR; r++) begin
            if (r > 0) begin
                for (int n = 0; n < 16; n++) s[n] = sbox_m[s[n]];
                for (int c = 0; c < 4; c++)
                    for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
                for (int n = 0; n < 16; n++) s[n] = t[n];
                if (r < NR) begin
                    for (int c = 0; c < 4; c++) begin
                        t[4*c+0] = gmul(s[4*c], 2) ^ gmul(s[4*c+1], 3) ^ s[4*c+2] ^ s[4*c+3];
                        t[4*c+1] = s[4*c] ^ gmul(s[4*c+1], 2) ^ gmul(s[4*c+2], 3) ^ s[4*c+3];
                        t[4*c+2] = s[4*c] ^ s[4*c+1] ^ gmul(s[4*c+2], 2) ^ gmul(s[4*c+3], 3);
                        t[4*c+3] = gmul(s[4*c], 3) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(s[4*c+3], 2);
                    end
                    for (int n = 0; n < 16; n++) s[n] = t[n];
                end
            end
            for (int n = 0; n < 16; n++) begin
                tmp  = w[4*r + n/4];
                s[n] = s[n] ^ tmp[31-8*(n%4) -: 8];
            end
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic logic [KEY_BITS-1:0] rand_key();
        logic [KEY_BITS-1:0] k;
        for (int i = 0; i < NK; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fips_vec(input int idx, output logic [127:0] pt,
                            output logic [KEY_BITS-1:0] key, output logic [127:0] ct);
        for (int b = 0; b < KEY_BITS / 8; b++) key[KEY_BITS-1-8*b -: 8] = 8'(b);
        pt = 128'h00112233445566778899aabbccddeeff;
        case (KEY_BITS)
            192:     ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
            256:     ct = 128'h8ea2b7ca516745bfeafc49904b496089;
            default: ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        endcase
        if (idx == 0 && KEY_BITS == 128) begin
            pt  = 128'h3243f6a8885a308d313198a2e0370734;
            key = KEY_BITS'(128'h2b7e151628aed2a6abf7158809cf4f3c);
            ct  = 128'h3925841d02dc09fbdc118597196a0b32;
        end
    endtask

    // ---------------- monitor ----------------
    logic seen = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n || !out_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h, expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("ciphertext", out_data, e.ct);
                    check("latency", 128'(cyc - e.acc), 128'(e.lat));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_block(input logic [127:0] pt, input logic [KEY_BITS-1:0] key,
                             input logic [127:0] ct_known, input bit use_known,
                             input int bp, input bit toggle);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        e.ct  = use_known ? ct_known : aes_model(pt, key);
        e.lat = FULL_LAT;
`ifdef AES_KEY_CACHE_EN
        if (cache_v && key == cache_key) begin
            e.lat = HIT_LAT;
        end else begin
            cache_v   = 1'b1;
            cache_key = key;
        end
`endif
        e.acc = cyc + 1;
        exp_q.push_back(e);
        in_valid  = 1'b1;
        in_data   = pt;
        in_key    = key;
        out_ready = (bp == 0);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            if (toggle) begin
                in_data  = rand_blk();
                in_key   = rand_key();
                in_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("out_valid_within_bound", out_valid, 1);
        if (!out_valid) begin
            exp_q.delete();
            return;
        end
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            check("bp_out_valid_held", out_valid, 1);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_data_stable", out_data, e.ct);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_after_handshake_in_ready", in_ready, 1);
        check("idle_after_handshake_out_valid", out_valid, 0);
    endtask

    task automatic reset_at(input logic [127:0] pt, input logic [KEY_BITS-1:0] key,
                            input int delay);
        check("in_ready_before_abort", in_ready, 1);
        in_valid = 1'b1;
        in_data  = pt;
        in_key   = key;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (delay) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        cache_v = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0]        pt, ct;
        logic [KEY_BITS-1:0] key, last_key;
        build_sbox();
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        fips_vec(0, pt, key, ct);
        run_block(pt, key, ct, 1'b1, 0, 1'b0);
        fips_vec(1, pt, key, ct);
        run_block(pt, key, ct, 1'b1, 0, 1'b0);
        run_block(rand_blk(), key, '0, 1'b0, 0, 1'b0);
        last_key = rand_key();
        run_block(rand_blk(), last_key, '0, 1'b0, 20, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) last_key = rand_key();
            run_block(rand_blk(), last_key, '0, 1'b0, 0, 1'b1);
        end

        reset_at(rand_blk(), rand_key(), 10);
        reset_at(rand_blk(), rand_key(), 4 * NR + 4 - NK + 2);
        fips_vec(1, pt, key, ct);
        run_block(pt, key, ct, 1'b1, 0, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 128'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
